// File: rtl/micro_pkg.sv
// rtl/micro_pkg.sv - opcode and state encodings shared by the sequencer slice
package micro_pkg;

   localparam int INSTR_WIDTH = 8;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_LW  = 2'b01;
   localparam logic [1:0] OP_SW  = 2'b10;
   localparam logic [1:0] OP_BEQ = 2'b11;

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_FETCH   = 3'd1;
   localparam logic [2:0] ST_DECODE  = 3'd2;
   localparam logic [2:0] ST_EXECUTE = 3'd3;
   localparam logic [2:0] ST_MEM     = 3'd4;
   localparam logic [2:0] ST_WB      = 3'd5;
   localparam logic [2:0] ST_DONE    = 3'd6;
   localparam logic [2:0] ST_HALT    = 3'd7;

   function automatic logic [1:0] opcode_of(input logic [INSTR_WIDTH-1:0] instr);
      return instr[INSTR_WIDTH-1 -: 2];
   endfunction

endpackage

// File: rtl/instruction_sequencer_if.sv
// rtl/instruction_sequencer_if.sv - sequencer <-> datapath/instruction-memory bus
interface instruction_sequencer_if #(
   parameter int ADDR_WIDTH = 8
);
   import micro_pkg::*;

   logic [ADDR_WIDTH-1:0]  read_address;
   logic [INSTR_WIDTH-1:0] instruction;
   logic [INSTR_WIDTH-1:0] ir;
   logic                   branch_taken;
   logic                   regwrite_en;
   logic                   memread_en;
   logic                   memwrite_en;

   modport master (
      output read_address, ir, regwrite_en, memread_en, memwrite_en,
      input  instruction, branch_taken
   );

   modport slave (
      input  read_address, ir, regwrite_en, memread_en, memwrite_en,
      output instruction, branch_taken
   );

endinterface

// File: rtl/instruction_sequencer_pc_unit.sv
// rtl/instruction_sequencer_pc_unit.sv - program counter with increment and signed 2-bit branch offset
module pc_unit #(
   parameter int                    ADDR_WIDTH = 8,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
   input  logic                  clock,
   input  logic                  clear,
   input  logic                  inc,
   input  logic                  branch,
   input  logic [1:0]            offset,
   output logic [ADDR_WIDTH-1:0] pc
);

   logic [ADDR_WIDTH-1:0] offset_ext;

   // Natural modulo-2**ADDR_WIDTH wrap of the adder gives FF->00 and 00-1->FF.
   assign offset_ext = {{(ADDR_WIDTH-2){offset[1]}}, offset};

   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         pc <= RESET_PC;
      end else if (inc) begin
         pc <= pc + ADDR_WIDTH'(1);
      end else if (branch) begin
         pc <= pc + offset_ext;
      end
   end

endmodule

// File: rtl/instruction_sequencer.sv
// rtl/instruction_sequencer.sv - tick-paced multi-cycle FSM: fetch/decode/execute with one-shot strobes
module instruction_sequencer
   import micro_pkg::*;
#(
   parameter int                    ADDR_WIDTH = 8,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
   parameter int                    CNT_WIDTH  = 16
) (
   input  logic                    clock,
   input  logic                    clear,
   input  logic                    tick,
   input  logic                    run,
   input  logic                    step,
   instruction_sequencer_if.master bus,
   output logic                    halted,
   output logic [2:0]              state_dbg,
   output logic [CNT_WIDTH-1:0]    retired
);

   logic [2:0]             state;
   logic [2:0]             state_nxt;
   logic [INSTR_WIDTH-1:0] ir_q;
   logic [1:0]             opcode;
   logic                   step_pending;
   logic                   pc_inc;
   logic                   pc_branch;

   assign opcode = opcode_of(ir_q);

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:    if (tick && (run || step_pending || step)) state_nxt = ST_FETCH;
         ST_FETCH:   if (tick) state_nxt = ST_DECODE;
         ST_DECODE:  if (tick) state_nxt = ST_EXECUTE;
         ST_EXECUTE: begin
            if (tick) begin
               case (opcode)
                  OP_ADD: state_nxt = ST_WB;
                  OP_LW:  state_nxt = ST_MEM;
                  OP_SW:  state_nxt = ST_MEM;
                  OP_BEQ: state_nxt = (bus.branch_taken && ir_q[1:0] == 2'b11) ? ST_HALT : ST_DONE;
               endcase
            end
         end
         ST_MEM:     if (tick) state_nxt = (opcode == OP_LW) ? ST_WB : ST_DONE;
         ST_WB:      if (tick) state_nxt = ST_DONE;
         ST_DONE:    state_nxt = run ? ST_FETCH : ST_IDLE;
         ST_HALT:    state_nxt = ST_HALT;
         default:    state_nxt = ST_IDLE;
      endcase
   end

   assign pc_inc    = (state == ST_FETCH) && tick;
   assign pc_branch = (state == ST_EXECUTE) && tick && (opcode == OP_BEQ) && bus.branch_taken;

   pc_unit #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .RESET_PC   (RESET_PC)
   ) u_pc (
      .clock  (clock),
      .clear  (clear),
      .inc    (pc_inc),
      .branch (pc_branch),
      .offset (ir_q[1:0]),
      .pc     (bus.read_address)
   );

   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         state        <= ST_IDLE;
         ir_q         <= '0;
         step_pending <= 1'b0;
         retired      <= '0;
      end else begin
         state <= state_nxt;
         if (pc_inc) ir_q <= bus.instruction;
         // A step pulse only arms while idle in step mode; leaving IDLE consumes it.
         if (state == ST_IDLE && state_nxt == ST_FETCH) begin
            step_pending <= 1'b0;
         end else if (state == ST_IDLE && !run && step) begin
            step_pending <= 1'b1;
         end
         if (state == ST_DONE && retired != '1) retired <= retired + CNT_WIDTH'(1);
      end
   end

   assign bus.ir          = ir_q;
   assign bus.memread_en  = (state == ST_MEM) && (opcode == OP_LW);
   assign bus.memwrite_en = (state == ST_MEM) && (opcode == OP_SW) && tick;
   assign bus.regwrite_en = (state == ST_WB) && tick;
   assign halted          = (state == ST_HALT);
   assign state_dbg       = state;

endmodule

// File: tb/tb_instruction_sequencer.sv
// tb/tb_instruction_sequencer.sv - randomized self-checking bench with instruction-level reference model
module tb_instruction_sequencer;
   import micro_pkg::*;

   logic        clock = 1'b0;
   logic        clear = 1'b0;
   logic        tick  = 1'b0;
   logic        run   = 1'b0;
   logic        step  = 1'b0;
   logic        taken_drv = 1'b0;
   logic        halted;
   logic [2:0]  state_dbg;
   logic [15:0] retired;
   logic [7:0]  mem [256];

   instruction_sequencer_if #(.ADDR_WIDTH(8)) bus ();

   assign bus.instruction  = mem[bus.read_address];
   assign bus.branch_taken = taken_drv;

   instruction_sequencer #(
      .ADDR_WIDTH (8),
      .RESET_PC   (8'h00),
      .CNT_WIDTH  (16)
   ) dut (
      .clock     (clock),
      .clear     (clear),
      .tick      (tick),
      .run       (run),
      .step      (step),
      .bus       (bus),
      .halted    (halted),
      .state_dbg (state_dbg),
      .retired   (retired)
   );

   always #5 clock = ~clock;

   int n_tests = 0;
   int n_fail  = 0;
   int rw_cnt, mw_cnt, mr_cnt;
   int viol = 0;
   int m_pc, m_ret;
   bit m_idle;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Write strobes must never appear on a clock without tick.
   always @(negedge clock) begin
      #2;
      if (!tick && (bus.regwrite_en || bus.memwrite_en)) viol++;
   end

   task automatic pulse_tick(input bit with_step);
      @(negedge clock);
      tick = 1'b1;
      step = with_step;
      #1;
      rw_cnt += int'(bus.regwrite_en);
      mw_cnt += int'(bus.memwrite_en);
      mr_cnt += int'(bus.memread_en);
      if (int'(bus.regwrite_en) + int'(bus.memwrite_en) + int'(bus.memread_en) > 1) viol++;
      if ((halted || state_dbg == ST_IDLE) && (bus.regwrite_en || bus.memwrite_en)) viol++;
      @(negedge clock);
      tick = 1'b0;
      step = 1'b0;
      @(negedge clock);
   endtask

   task automatic pulse_step();
      @(negedge clock);
      step = 1'b1;
      @(negedge clock);
      step = 1'b0;
   endtask

   task automatic do_clear();
      @(negedge clock);
      clear = 1'b0;
      #1;
      check("clr_pc", 32'(bus.read_address), 32'h00);
      check("clr_ir", 32'(bus.ir), 32'h00);
      check("clr_retired", 32'(retired), 32'h0);
      check("clr_halted", 32'(halted), 32'h0);
      check("clr_state", 32'(state_dbg), 32'(ST_IDLE));
      @(negedge clock);
      clear = 1'b1;
      m_pc = 0; m_ret = 0; m_idle = 1'b1;
   endtask

   function automatic int sext2(input logic [1:0] o);
      return o[1] ? int'(o) - 4 : int'(o);
   endfunction

   // Ticks while nothing should be running: PC, count and IDLE must hold.
   task automatic idle_ticks(input int n);
      rw_cnt = 0; mw_cnt = 0; mr_cnt = 0;
      for (int i = 0; i < n; i++) pulse_tick(1'b0);
      check("idle_pc", 32'(bus.read_address), 32'(m_pc));
      check("idle_retired", 32'(retired), 32'(m_ret));
      check("idle_state", 32'(state_dbg), 32'(ST_IDLE));
      check("idle_strobes", 32'(rw_cnt + mw_cnt), 32'h0);
   endtask

   // mode: 0 run/continue, 1 step pulse then tick, 2 step and tick in same clock.
   // force_taken: -1 random, otherwise the branch_taken value to drive.
   task automatic exec_one(input int mode, input bit drop_run, input bit step_mid, input int force_taken);
      logic [7:0] ins;
      bit taken, is_beq, halt_exp;
      int lat, exp_rw, exp_mw, exp_mr;
      ins = mem[m_pc[7:0]];
      taken = (force_taken < 0) ? bit'($urandom_range(0, 1)) : bit'(force_taken);
      taken_drv = taken;
      is_beq = (ins[7:6] == 2'b11);
      lat    = (ins[7:6] == 2'b01) ? 5 : (ins[7:6] == 2'b11) ? 3 : 4;
      exp_rw = (ins[7:6] == 2'b00 || ins[7:6] == 2'b01) ? 1 : 0;
      exp_mr = (ins[7:6] == 2'b01) ? 1 : 0;
      exp_mw = (ins[7:6] == 2'b10) ? 1 : 0;
      rw_cnt = 0; mw_cnt = 0; mr_cnt = 0;
      if (mode == 1) pulse_step();
      if (m_idle) pulse_tick(mode == 2);
      for (int i = 0; i < lat; i++) begin
         if (step_mid && i == 2) pulse_step();
         if (drop_run && i == 1) run = 1'b0;
         pulse_tick(1'b0);
      end
      halt_exp = is_beq && taken && (ins[1:0] == 2'b11);
      m_pc = (m_pc + 1 + ((is_beq && taken) ? sext2(ins[1:0]) : 0)) & 255;
      if (!halt_exp && m_ret < 65535) m_ret++;
      m_idle = !halt_exp && !run;
      check("pc", 32'(bus.read_address), 32'(m_pc));
      check("ir", 32'(bus.ir), 32'(ins));
      check("retired", 32'(retired), 32'(m_ret));
      check("halted", 32'(halted), 32'(halt_exp));
      check("regwrite_pulses", 32'(rw_cnt), 32'(exp_rw));
      check("memwrite_pulses", 32'(mw_cnt), 32'(exp_mw));
      check("memread_ticks", 32'(mr_cnt), 32'(exp_mr));
      if (m_idle) check("back_to_idle", 32'(state_dbg), 32'(ST_IDLE));
   endtask

   task automatic after_halt();
      rw_cnt = 0; mw_cnt = 0;
      for (int i = 0; i < 3; i++) pulse_tick(1'b0);
      check("halt_stays", 32'(halted), 32'h1);
      check("halt_pc", 32'(bus.read_address), 32'(m_pc));
      check("halt_retired", 32'(retired), 32'(m_ret));
      check("halt_strobes", 32'(rw_cnt + mw_cnt), 32'h0);
      do_clear();
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
      m_pc = 0; m_ret = 0; m_idle = 1'b1;
      repeat (3) @(negedge clock);
      #1;
      check("rst_pc", 32'(bus.read_address), 32'h00);
      check("rst_retired", 32'(retired), 32'h0);
      check("rst_state", 32'(state_dbg), 32'(ST_IDLE));
      check("rst_strobes", 32'({bus.regwrite_en, bus.memread_en, bus.memwrite_en, halted}), 32'h0);
      @(negedge clock);
      clear = 1'b1;

      // Clear while sitting in MEM of an SW: no write strobe, PC and state reset.
      mem[0] = 8'h86;
      run = 1'b1;
      mw_cnt = 0;
      for (int i = 0; i < 4; i++) pulse_tick(1'b0);
      @(negedge clock);
      clear = 1'b0;
      tick  = 1'b1;
      #1;
      check("midsw_memwrite", 32'(bus.memwrite_en), 32'h0);
      check("midsw_pc", 32'(bus.read_address), 32'h00);
      check("midsw_state", 32'(state_dbg), 32'(ST_IDLE));
      check("midsw_no_pulse", 32'(mw_cnt), 32'h0);
      @(negedge clock);
      tick  = 1'b0;
      clear = 1'b1;
      m_pc = 0; m_ret = 0; m_idle = 1'b1;

      // ADD then LW then SW in run mode.
      mem[0] = 8'h06; mem[1] = 8'h45; mem[2] = 8'h86;
      exec_one(0, 1'b0, 1'b0, -1);
      check("add_pc", 32'(bus.read_address), 32'h01);
      exec_one(0, 1'b0, 1'b0, -1);
      exec_one(0, 1'b0, 1'b0, -1);
      check("lwsw_retired", 32'(retired), 32'h3);

      // BEQ +1 at PC 05, taken and not taken.
      for (int t = 1; t >= 0; t--) begin
         do_clear();
         for (int i = 0; i < 256; i++) mem[i] = 8'h00;
         mem[5] = 8'hC1;
         run = 1'b1;
         for (int i = 0; i < 5; i++) exec_one(0, 1'b0, 1'b0, 0);
         exec_one(0, 1'b0, 1'b0, t);
         check("beq_pc", 32'(bus.read_address), (t == 1) ? 32'h07 : 32'h06);
      end

      // Branch back to FF, then self-branch at FF wraps through 00 and halts.
      do_clear();
      mem[0] = 8'hC2; mem[255] = 8'hFF;
      exec_one(0, 1'b0, 1'b0, 1);
      check("wrap_pc", 32'(bus.read_address), 32'hFF);
      exec_one(0, 1'b0, 1'b0, 1);
      check("selfloop_pc", 32'(bus.read_address), 32'hFF);
      after_halt();

      // Single-step: step ignored during EXECUTE, idle between steps.
      run = 1'b0;
      mem[0] = 8'h06; mem[1] = 8'h45; mem[2] = 8'h81; mem[3] = 8'h02;
      exec_one(1, 1'b0, 1'b1, -1);
      idle_ticks(10);
      exec_one(1, 1'b0, 1'b0, -1);
      check("step_retired", 32'(retired), 32'h2);
      exec_one(2, 1'b0, 1'b0, -1);
      // run dropped mid-instruction: finishes, then idles.
      run = 1'b1;
      exec_one(0, 1'b1, 1'b0, -1);
      idle_ticks(4);

      // Random programs in run mode.
      do_clear();
      for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
      run = 1'b1;
      for (int k = 0; k < 60; k++) begin
         exec_one(0, 1'b0, 1'b0, -1);
         if (halted) begin
            m_idle = 1'b0;
            after_halt();
         end
      end

      check("strobe_rules", 32'(viol), 32'h0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
